// File: rtl/qdec_pkg.sv
`default_nettype none
// ============================================================================
// Module      : qdec_pkg
// Description : Shared types, constants and the phase-transition classifier
//               for the quadrature decoder.
//               phase_t encodes {filtered A, filtered B} directly, so a state
//               can be cast from the two filter outputs with no lookup.
// Revision    : 1.0 - initial release
// ============================================================================
package qdec_pkg;

  typedef enum logic [1:0] {
    S00 = 2'b00,
    S01 = 2'b01,
    S11 = 2'b11,
    S10 = 2'b10
  } phase_t;

  localparam logic DIR_UP = 1'b1;
  localparam logic DIR_DN = 1'b0;

  // Classification of one sampled phase transition.
  typedef struct packed {
    logic legal;    // exactly one bit changed
    logic up;       // valid only with legal: A leads B
    logic illegal;  // both bits changed at once
  } step_t;

  // Up order is 00 -> 10 -> 11 -> 01 -> 00; the reverse order is down.
  function automatic step_t step_dir(input phase_t prev, input phase_t cur);
    step_t r;
    logic [1:0] diff;
    r    = '{legal: 1'b0, up: 1'b0, illegal: 1'b0};
    diff = prev ^ cur;
    if (diff == 2'b11) begin
      r.illegal = 1'b1;
    end else if (diff != 2'b00) begin
      r.legal = 1'b1;
      case (prev)
        S00:     r.up = (cur == S10);
        S10:     r.up = (cur == S11);
        S11:     r.up = (cur == S01);
        default: r.up = (cur == S00);
      endcase
    end
    return r;
  endfunction

endpackage : qdec_pkg
`default_nettype wire

// File: rtl/quad_input_filter.sv
`default_nettype none
// ============================================================================
// Module      : quad_input_filter
// Description : Two-flop synchronizer followed by a run-length glitch filter
//               for one asynchronous encoder line. The filtered output only
//               changes after FILT_LEN consecutive synchronized samples
//               disagree with it; any agreeing sample restarts the run.
// Ports       : clk  - system clock
//               rst  - asynchronous active-low reset (all state to 0)
//               din  - raw asynchronous input
//               dout - synchronized, filtered output
// Parameters  : FILT_LEN - required run length, 2..16
// Revision    : 1.0 - initial release
// ============================================================================
module quad_input_filter #(
  parameter int FILT_LEN = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic dout
);

  localparam int            CW       = $clog2(FILT_LEN);
  localparam logic [CW-1:0] RUN_LAST = CW'(FILT_LEN - 1);
  localparam logic [CW-1:0] RUN_INC  = CW'(1);

  logic          sync1;
  logic          sync2;
  logic          filt;
  logic [CW-1:0] run;

  // run holds the number of disagreeing samples already seen, so the
  // FILT_LEN-th disagreeing sample is the one that finds run == RUN_LAST.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      filt  <= 1'b0;
      run   <= '0;
    end else begin
      sync1 <= din;
      sync2 <= sync1;
      if (sync2 != filt) begin
        if (run == RUN_LAST) begin
          filt <= sync2;
          run  <= '0;
        end else begin
          run <= run + RUN_INC;
        end
      end else begin
        run <= '0;
      end
    end
  end

  assign dout = filt;

endmodule : quad_input_filter
`default_nettype wire

// File: rtl/quad_decoder.sv
`default_nettype none
// ============================================================================
// Module      : quad_decoder
// Description : x4 quadrature decoder. Filtered A/B phases drive a phase
//               state machine; each legal edge produces a one-cycle step
//               strobe and moves a WIDTH-bit position count up or down
//               (wrapping or saturating). A simultaneous change of both
//               phases sets a sticky error flag instead of counting.
// Ports       : clk   - system clock
//               rst   - asynchronous active-low reset
//               enc_a - encoder phase A (asynchronous)
//               enc_b - encoder phase B (asynchronous)
//               enc_z - index pulse (asynchronous), only with QDEC_INDEX_EN
//               clr   - synchronous clear of count and err
//               count - unsigned position count
//               dir   - last step direction, 1 = up (A leads B)
//               step  - one-cycle strobe per accepted step
//               err   - sticky illegal-transition flag
// Parameters  : WIDTH    - count width
//               FILT_LEN - glitch filter run length (2..16)
//               WRAP     - 1 = modulo count, 0 = saturate at 0 / 2^WIDTH-1
// Options     : QDEC_INDEX_EN - adds enc_z; a rising filtered index edge
//               while the phase state is S00 loads count with 0.
// Revision    : 1.0 - initial release
// ============================================================================
module quad_decoder
  import qdec_pkg::*;
#(
  parameter int WIDTH    = 5,
  parameter int FILT_LEN = 4,
  parameter int WRAP     = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enc_a,
  input  logic             enc_b,
`ifdef QDEC_INDEX_EN
  input  logic             enc_z,
`endif
  input  logic             clr,
  output logic [WIDTH-1:0] count,
  output logic             dir,
  output logic             step,
  output logic             err
);

  localparam logic [WIDTH-1:0] CNT_MAX = '1;
  localparam logic [WIDTH-1:0] CNT_ONE = WIDTH'(1);
  localparam bit               SAT     = (WRAP == 0);

  logic             filt_a;
  logic             filt_b;
  phase_t           cur_phase;
  step_t            trans;
  logic             index_hit;

  phase_t           phase_q,  phase_d;
  logic [WIDTH-1:0] count_q,  count_d;
  logic             dir_q,    dir_d;
  logic             step_q,   step_d;
  logic             err_q,    err_d;

  // --------------------------------------------------------------------------
  // Input conditioning
  // --------------------------------------------------------------------------
  quad_input_filter #(.FILT_LEN(FILT_LEN)) u_filt_a (
    .clk  (clk),
    .rst  (rst),
    .din  (enc_a),
    .dout (filt_a)
  );

  quad_input_filter #(.FILT_LEN(FILT_LEN)) u_filt_b (
    .clk  (clk),
    .rst  (rst),
    .din  (enc_b),
    .dout (filt_b)
  );

`ifdef QDEC_INDEX_EN
  logic filt_z;
  logic z_q;

  quad_input_filter #(.FILT_LEN(FILT_LEN)) u_filt_z (
    .clk  (clk),
    .rst  (rst),
    .din  (enc_z),
    .dout (filt_z)
  );

  // Previous filtered index level, for rising-edge detection.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      z_q <= 1'b0;
    end else begin
      z_q <= filt_z;
    end
  end

  // Qualified by the registered phase, i.e. the state the mechanism was
  // resting in when the index mark arrived.
  assign index_hit = filt_z && !z_q && (phase_q == S00);
`else
  assign index_hit = 1'b0;
`endif

  // --------------------------------------------------------------------------
  // Phase state machine and outputs
  // --------------------------------------------------------------------------
  assign cur_phase = phase_t'({filt_a, filt_b});
  assign trans     = step_dir(phase_q, cur_phase);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      phase_q <= S00;
      count_q <= '0;
      dir_q   <= DIR_DN;
      step_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      phase_q <= phase_d;
      count_q <= count_d;
      dir_q   <= dir_d;
      step_q  <= step_d;
      err_q   <= err_d;
    end
  end

  // Priority on count, lowest to highest: step, index, clr.
  always_comb begin
    phase_d = cur_phase;  // always track, including after an illegal jump
    count_d = count_q;
    dir_d   = dir_q;
    step_d  = 1'b0;
    err_d   = err_q;

    if (trans.legal) begin
      step_d = 1'b1;
      if (trans.up) begin
        dir_d = DIR_UP;
        if (!SAT || (count_q != CNT_MAX)) begin
          count_d = count_q + CNT_ONE;
        end
      end else begin
        dir_d = DIR_DN;
        if (!SAT || (count_q != '0)) begin
          count_d = count_q - CNT_ONE;
        end
      end
    end

    if (trans.illegal) begin
      err_d = 1'b1;
    end

    if (index_hit) begin
      count_d = '0;
    end

    if (clr) begin
      count_d = '0;
      err_d   = 1'b0;
    end
  end

  assign count = count_q;
  assign dir   = dir_q;
  assign step  = step_q;
  assign err   = err_q;

endmodule : quad_decoder
`default_nettype wire

// File: tb/tb_quad_decoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_quad_decoder
// Description : Self-checking bench for quad_decoder. Two instances share the
//               stimulus: one wrapping (WRAP=1), one saturating (WRAP=0).
//               A fixed vector table covers the hand-derived corner cases,
//               followed by directed sequences and random phase moves
//               checked against a position/quadrant reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_quad_decoder;

  localparam int WIDTH    = 5;
  localparam int FILT_LEN = 4;
  localparam int MAXC     = (1 << WIDTH) - 1;
  localparam int HOLD     = FILT_LEN + 8;
  localparam int LAT      = FILT_LEN + 3;

  logic             clk = 1'b0;
  logic             rst;
  logic             enc_a;
  logic             enc_b;
  logic             clr;
`ifdef QDEC_INDEX_EN
  logic             enc_z;
`endif
  logic [WIDTH-1:0] count_w, count_s;
  logic             dir_w, dir_s;
  logic             step_w, step_s;
  logic             err_w, err_s;

  int n_pass = 0;
  int n_tot  = 0;

  always #5 clk = ~clk;

  quad_decoder #(.WIDTH(WIDTH), .FILT_LEN(FILT_LEN), .WRAP(1)) dut_w (
    .clk   (clk),
    .rst   (rst),
    .enc_a (enc_a),
    .enc_b (enc_b),
`ifdef QDEC_INDEX_EN
    .enc_z (enc_z),
`endif
    .clr   (clr),
    .count (count_w),
    .dir   (dir_w),
    .step  (step_w),
    .err   (err_w)
  );

  quad_decoder #(.WIDTH(WIDTH), .FILT_LEN(FILT_LEN), .WRAP(0)) dut_s (
    .clk   (clk),
    .rst   (rst),
    .enc_a (enc_a),
    .enc_b (enc_b),
`ifdef QDEC_INDEX_EN
    .enc_z (enc_z),
`endif
    .clr   (clr),
    .count (count_s),
    .dir   (dir_s),
    .step  (step_s),
    .err   (err_s)
  );

  // ---------------------------------------------------------------------------
  // Reference model: the encoder position is a quadrant index 0..3 around the
  // Gray cycle 00,10,11,01. A move of +1 quadrant is up, -1 is down, 2 is an
  // undecodable jump.
  // ---------------------------------------------------------------------------
  logic [1:0] m_phase;
  int         m_w, m_s;
  int         m_dir, m_err;

  function automatic int qidx(input logic [1:0] p);
    case (p)
      2'b00:   return 0;
      2'b10:   return 1;
      2'b11:   return 2;
      default: return 3;
    endcase
  endfunction

  function automatic logic [1:0] qphase(input int i);
    case (i % 4)
      0:       return 2'b00;
      1:       return 2'b10;
      2:       return 2'b11;
      default: return 2'b01;
    endcase
  endfunction

  task automatic model_reset();
    m_phase = 2'b00; m_w = 0; m_s = 0; m_dir = 0; m_err = 0;
  endtask

  task automatic model_move(input logic [1:0] p, output int exp_step);
    int d;
    d = (qidx(p) - qidx(m_phase) + 4) % 4;
    exp_step = 0;
    if (d == 1) begin
      exp_step = 1; m_dir = 1;
      m_w = (m_w + 1) % (MAXC + 1);
      m_s = (m_s < MAXC) ? m_s + 1 : MAXC;
    end else if (d == 3) begin
      exp_step = 1; m_dir = 0;
      m_w = (m_w + MAXC) % (MAXC + 1);
      m_s = (m_s > 0) ? m_s - 1 : 0;
    end else if (d == 2) begin
      m_err = 1;
    end
    m_phase = p;
  endtask

  // ---------------------------------------------------------------------------
  // Helpers
  // ---------------------------------------------------------------------------
  task automatic chk(input string name, input int act, input int exp);
    n_tot++;
    if (act != exp) begin
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end else begin
      n_pass++;
    end
  endtask

  task automatic drive(input logic [1:0] p);
    @(posedge clk);
    #1;
    enc_a = p[1];
    enc_b = p[0];
  endtask

  // Watches a fixed window of cycles; reports step pulses and the cycle of
  // the first one (1 = first sample after the driving edge).
  task automatic settle(output int nw, output int ns, output int first);
    nw = 0; ns = 0; first = 0;
    for (int c = 1; c <= HOLD; c++) begin
      @(posedge clk);
      @(negedge clk);
      if (step_w) begin
        nw++;
        if (first == 0) first = c;
      end
      if (step_s) ns++;
    end
  endtask

  task automatic check_state(input string tag);
    chk({tag, " count_w"}, int'(count_w), m_w);
    chk({tag, " count_s"}, int'(count_s), m_s);
    chk({tag, " dir_w"},   int'(dir_w),   m_dir);
    chk({tag, " dir_s"},   int'(dir_s),   m_dir);
    chk({tag, " err_w"},   int'(err_w),   m_err);
    chk({tag, " err_s"},   int'(err_s),   m_err);
  endtask

  task automatic move_chk(input string tag, input logic [1:0] p);
    int nw, ns, first, exp_step;
    model_move(p, exp_step);
    drive(p);
    settle(nw, ns, first);
    chk({tag, " steps_w"}, nw, exp_step);
    chk({tag, " steps_s"}, ns, exp_step);
    if (exp_step == 1) chk({tag, " latency"}, first, LAT);
    check_state(tag);
  endtask

  task automatic pulse_clr();
    @(posedge clk);
    #1 clr = 1'b1;
    @(posedge clk);
    #1 clr = 1'b0;
    m_w = 0; m_s = 0; m_err = 0;
    @(negedge clk);
  endtask

  task automatic do_reset();
    enc_a = 1'b0;
    enc_b = 1'b0;
    clr   = 1'b0;
`ifdef QDEC_INDEX_EN
    enc_z = 1'b0;
`endif
    @(posedge clk);
    #2 rst = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
  endtask

  // ---------------------------------------------------------------------------
  // Vector table
  // ---------------------------------------------------------------------------
  typedef struct {
    logic [1:0] ph;
    int         steps;
    int         cw;
    int         cs;
    int         dir;
    int         err;
  } vec_t;

  vec_t tbl [8];

  initial begin
    int nw, ns, first;

    rst   = 1'b0;
    enc_a = 1'b0;
    enc_b = 1'b0;
    clr   = 1'b0;
`ifdef QDEC_INDEX_EN
    enc_z = 1'b0;
`endif
    model_reset();

    // Reset state, observed while rst is still low.
    #1;
    chk("reset count_w", int'(count_w), 0);
    chk("reset count_s", int'(count_s), 0);
    chk("reset dir",     int'(dir_w),   0);
    chk("reset step",    int'(step_w),  0);
    chk("reset err",     int'(err_w),   0);

    // ---- Table: from reset, WRAP boundary, hold, reversal, double change.
    tbl[0] = '{2'b01, 1, 31, 0, 0, 0};  // down from 0: wrap vs saturate
    tbl[1] = '{2'b00, 1,  0, 1, 1, 0};  // up: 31 -> 0 on the wrapping side
    tbl[2] = '{2'b10, 1,  1, 2, 1, 0};
    tbl[3] = '{2'b11, 1,  2, 3, 1, 0};
    tbl[4] = '{2'b11, 0,  2, 3, 1, 0};  // no change: everything holds
    tbl[5] = '{2'b10, 1,  1, 2, 0, 0};  // reversal
    tbl[6] = '{2'b01, 0,  1, 2, 0, 1};  // both bits flip: err, no count
    tbl[7] = '{2'b00, 1,  2, 3, 1, 1};  // err stays sticky
    do_reset();
    for (int i = 0; i < 8; i++) begin
      drive(tbl[i].ph);
      settle(nw, ns, first);
      chk($sformatf("tbl%0d steps_w", i), nw, tbl[i].steps);
      chk($sformatf("tbl%0d steps_s", i), ns, tbl[i].steps);
      chk($sformatf("tbl%0d count_w", i), int'(count_w), tbl[i].cw);
      chk($sformatf("tbl%0d count_s", i), int'(count_s), tbl[i].cs);
      chk($sformatf("tbl%0d dir", i),     int'(dir_w),   tbl[i].dir);
      chk($sformatf("tbl%0d err", i),     int'(err_w),   tbl[i].err);
    end
    // clr zeroes count and err but leaves dir alone.
    pulse_clr();
    chk("clr count_w", int'(count_w), 0);
    chk("clr count_s", int'(count_s), 0);
    chk("clr err",     int'(err_w),   0);
    chk("clr dir",     int'(dir_w),   1);

    // ---- Four full up cycles, then four more to hit saturation / wrap.
    do_reset();
    begin
      int total;
      total = 0;
      for (int i = 1; i <= 16; i++) begin
        model_move(qphase(i), first);
        drive(qphase(i));
        settle(nw, ns, first);
        total += nw;
      end
      chk("up16 steps", total, 16);
      check_state("up16");
    end
    for (int i = 17; i <= 32; i++) move_chk("up32", qphase(i));

    // ---- Glitch on A shorter than the filter run.
    do_reset();
    @(posedge clk);
    #1 enc_a = 1'b1;
    repeat (FILT_LEN - 1) @(posedge clk);
    #1 enc_a = 1'b0;
    settle(nw, ns, first);
    chk("glitch steps", nw, 0);
    check_state("glitch");

    // ---- Double change 00 -> 11 then clr.
    move_chk("dbl", 2'b11);
    pulse_clr();
    check_state("dbl clr");

    // ---- Asynchronous reset while a step strobe is high at count 7.
    do_reset();
    for (int i = 1; i <= 7; i++) move_chk("pre_rst", qphase(i));
    drive(qphase(8));
    repeat (LAT) @(posedge clk);
    #2;
    chk("mid step", int'(step_w), 1);
    rst = 1'b0;
    #1;
    chk("async count", int'(count_w), 0);
    chk("async dir",   int'(dir_w),   0);
    chk("async step",  int'(step_w),  0);
    chk("async err",   int'(err_w),   0);

    // ---- Random phase moves with occasional clr.
    do_reset();
    for (int i = 0; i < 48; i++) begin
      if ($urandom_range(0, 9) == 0) begin
        pulse_clr();
        check_state("rnd clr");
      end
      move_chk("rnd", 2'($urandom_range(0, 3)));
    end

`ifdef QDEC_INDEX_EN
    // ---- Index: count 9 resting in S00, then index in S11.
    do_reset();
    move_chk("idx", 2'b10);
    pulse_clr();
    move_chk("idx", 2'b01);                 // double change shifts quadrant
    for (int i = 4; i <= 12; i++) move_chk("idx", qphase(i));
    chk("idx pre count", int'(count_w), 9);
    @(posedge clk);
    #1 enc_z = 1'b1;
    settle(nw, ns, first);
    #1 enc_z = 1'b0;
    settle(nw, ns, first);
    m_w = 0; m_s = 0;
    check_state("idx s00");
    move_chk("idx", 2'b10);
    move_chk("idx", 2'b11);
    @(posedge clk);
    #1 enc_z = 1'b1;
    settle(nw, ns, first);
    #1 enc_z = 1'b0;
    settle(nw, ns, first);
    check_state("idx s11");
`endif

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule : tb_quad_decoder
`default_nettype wire
